// File: rtl/knn_vote_pkg.sv
// Shared definitions for the KNN majority-vote stage: FSM state encodings and
// default neighbour-list geometry shared with the upstream list stage.
package knn_vote_pkg;

  localparam int KNN_N_NEIGHBOUR_DEF = 10;
  localparam int KNN_LABEL_DEF       = 8;

  typedef enum logic [1:0] {
    KNN_VOTE_IDLE = 2'd0,
    KNN_VOTE_SCAN = 2'd1,
    KNN_VOTE_DONE = 2'd2
  } knn_vote_state_e;

endpackage

// File: rtl/knn_vote_if.sv
// Handshake/data bundle between the neighbour-list stage (master) and knn_vote (slave).
// Optional vote_cnt signal present when KNN_VOTE_COUNT_EN is defined.
interface knn_vote_if #(
  parameter int N_NEIGHBOUR = 10,
  parameter int LABEL       = 8
);
  localparam int CNT_W = $clog2(N_NEIGHBOUR + 1);

  logic                         start;
  logic [LABEL*N_NEIGHBOUR-1:0] neighbour_labels;
  logic [CNT_W-1:0]             n_valid;
  logic                         busy;
  logic                         done;
  logic [LABEL-1:0]             label_out;
`ifdef KNN_VOTE_COUNT_EN
  logic [CNT_W-1:0]             vote_cnt;
`endif

  modport master (
    output start, neighbour_labels, n_valid,
`ifdef KNN_VOTE_COUNT_EN
    input  vote_cnt,
`endif
    input  busy, done, label_out
  );

  modport slave (
    input  start, neighbour_labels, n_valid,
`ifdef KNN_VOTE_COUNT_EN
    output vote_cnt,
`endif
    output busy, done, label_out
  );
endinterface

// File: rtl/knn_match_count.sv
// Counts how many of the first i_nv label slots equal the reference label.
module knn_match_count #(
  parameter int N_NEIGHBOUR = 10,
  parameter int LABEL       = 8,
  localparam int CNT_W      = $clog2(N_NEIGHBOUR + 1)
) (
  input  logic [LABEL*N_NEIGHBOUR-1:0] i_labels,
  input  logic [LABEL-1:0]             i_ref,
  input  logic [CNT_W-1:0]             i_nv,
  output logic [CNT_W-1:0]             o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int j = 0; j < N_NEIGHBOUR; j++) begin
      if ((CNT_W'(j) < i_nv) && (i_labels[j*LABEL +: LABEL] == i_ref))
        o_cnt = o_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/knn_vote.sv
// Sequential majority vote over the snapshotted KNN neighbour labels; ties go
// to the nearest first occurrence. Optional vote_cnt output: KNN_VOTE_COUNT_EN.
module knn_vote
  import knn_vote_pkg::*;
#(
  parameter int N_NEIGHBOUR = KNN_N_NEIGHBOUR_DEF,
  parameter int LABEL       = KNN_LABEL_DEF,
  localparam int CNT_W      = $clog2(N_NEIGHBOUR + 1)
) (
  input logic        clk,
  input logic        rst,
  knn_vote_if.slave  bus
);

  knn_vote_state_e              r_state;
  logic [LABEL*N_NEIGHBOUR-1:0] r_lab;
  logic [CNT_W-1:0]             r_nv;
  logic [CNT_W-1:0]             r_idx;
  logic [CNT_W-1:0]             r_best_cnt;
  logic [LABEL-1:0]             r_best_lab;
  logic                         r_done;
  logic [LABEL-1:0]             r_label_out;
  logic [CNT_W-1:0]             r_vote_cnt;

  logic [CNT_W-1:0]             w_nv_clamp;
  logic [LABEL-1:0]             w_ref;
  logic [CNT_W-1:0]             w_cnt;

  assign w_nv_clamp = (bus.n_valid > CNT_W'(N_NEIGHBOUR)) ? CNT_W'(N_NEIGHBOUR) : bus.n_valid;

  always_comb begin
    w_ref = '0;
    for (int i = 0; i < N_NEIGHBOUR; i++) begin
      if (r_idx == CNT_W'(i)) w_ref = r_lab[i*LABEL +: LABEL];
    end
  end

  knn_match_count #(
    .N_NEIGHBOUR (N_NEIGHBOUR),
    .LABEL       (LABEL)
  ) u_match (
    .i_labels (r_lab),
    .i_ref    (w_ref),
    .i_nv     (r_nv),
    .o_cnt    (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= KNN_VOTE_IDLE;
      r_lab       <= '0;
      r_nv        <= '0;
      r_idx       <= '0;
      r_best_cnt  <= '0;
      r_best_lab  <= '0;
      r_done      <= 1'b0;
      r_label_out <= '0;
      r_vote_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        KNN_VOTE_IDLE: begin
          if (bus.start) begin
            r_lab      <= bus.neighbour_labels;
            r_nv       <= w_nv_clamp;
            r_idx      <= '0;
            r_best_cnt <= '0;
            r_best_lab <= '0;
            r_state    <= (w_nv_clamp == '0) ? KNN_VOTE_DONE : KNN_VOTE_SCAN;
          end
        end
        KNN_VOTE_SCAN: begin
          // Strict greater-than keeps the earliest (nearest) label on ties.
          if (w_cnt > r_best_cnt) begin
            r_best_cnt <= w_cnt;
            r_best_lab <= w_ref;
          end
          if (r_idx == r_nv - CNT_W'(1)) r_state <= KNN_VOTE_DONE;
          else                           r_idx   <= r_idx + CNT_W'(1);
        end
        KNN_VOTE_DONE: begin
          r_done      <= 1'b1;
          r_label_out <= r_best_lab;
          r_vote_cnt  <= r_best_cnt;
          r_state     <= KNN_VOTE_IDLE;
        end
        default: r_state <= KNN_VOTE_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state != KNN_VOTE_IDLE);
  assign bus.done      = r_done;
  assign bus.label_out = r_label_out;

`ifdef KNN_VOTE_COUNT_EN
  assign bus.vote_cnt  = r_vote_cnt;
`else
  logic w_unused_vote_cnt;
  assign w_unused_vote_cnt = ^r_vote_cnt;
`endif

endmodule

// File: tb/tb_knn_vote.sv
// Directed self-checking bench for knn_vote with hand-computed vote results.
module tb_knn_vote;
  localparam int NN = 10;
  localparam int LB = 8;
  localparam int CW = $clog2(NN + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  knn_vote_if #(.N_NEIGHBOUR(NN), .LABEL(LB)) bus ();

  knn_vote #(.N_NEIGHBOUR(NN), .LABEL(LB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [LB*NN-1:0] pack10(input int l0, l1, l2, l3, l4, l5, l6, l7, l8, l9);
    logic [LB*NN-1:0] v;
    v = {LB'(l9), LB'(l8), LB'(l7), LB'(l6), LB'(l5), LB'(l4), LB'(l3), LB'(l2), LB'(l1), LB'(l0)};
    return v;
  endfunction

  // Presents one start and waits for done; returns edges counted after the start edge.
  task automatic run_vote(input logic [LB*NN-1:0] labs, input int nv, output int lat);
    @(negedge clk);
    bus.neighbour_labels = labs;
    bus.n_valid          = CW'(nv);
    bus.start            = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) break;
    end
    if (!bus.done) lat = -1;
  endtask

  task automatic vote_case(input string tag, input logic [LB*NN-1:0] labs, input int nv,
                           input int exp_lab, input int exp_cnt, input int exp_lat);
    int lat;
    run_vote(labs, nv, lat);
    check_eq({tag, "_lat"},   lat, exp_lat);
    check_eq({tag, "_label"}, bus.label_out, exp_lab);
`ifdef KNN_VOTE_COUNT_EN
    check_eq({tag, "_cnt"},   bus.vote_cnt, exp_cnt);
`else
    if (exp_cnt < 0) $display("note: negative expected count in %s", tag);
`endif
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, bus.done, 1'b0);
  endtask

  logic [LB*NN-1:0] t1;
  int lat, dones;

  initial begin
    bus.start            = 1'b0;
    bus.neighbour_labels = '0;
    bus.n_valid          = '0;
    t1 = pack10(3, 5, 3, 7, 5, 3, 1, 1, 2, 9);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",  bus.busy, 1'b0);
    check_eq("rst_done",  bus.done, 1'b0);
    check_eq("rst_label", bus.label_out, 0);
    rst = 1'b0;

    vote_case("main",   t1, 10, 3, 3, 11);
    vote_case("tie_a",  pack10(4, 6, 6, 4, 0, 0, 0, 0, 0, 0), 4, 4, 2, 5);
    vote_case("tie_b",  pack10(6, 4, 4, 6, 0, 0, 0, 0, 0, 0), 4, 6, 2, 5);
    vote_case("nv0",    t1, 0, 0, 0, 1);
    vote_case("clamp",  t1, 15, 3, 3, 11);
    vote_case("mask",   pack10(2, 8, 9, 9, 9, 9, 9, 9, 9, 9), 3, 2, 1, 4);
    vote_case("single", pack10(77, 1, 1, 1, 1, 1, 1, 1, 1, 1), 1, 77, 1, 2);

    // Snapshot: perturb inputs and re-pulse start during the scan.
    @(negedge clk);
    bus.neighbour_labels = t1;
    bus.n_valid          = CW'(10);
    bus.start            = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check_eq("snap_busy", bus.busy, 1'b1);
    bus.neighbour_labels = pack10(7, 7, 7, 7, 7, 7, 7, 7, 7, 7);
    bus.n_valid          = CW'(4);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        check_eq("snap_label", bus.label_out, 3);
      end
    end
    check_eq("snap_dones", dones, 1);
    check_eq("snap_idle", bus.busy, 1'b0);

    // Reset during scan aborts without a done pulse.
    @(negedge clk);
    bus.neighbour_labels = t1;
    bus.n_valid          = CW'(10);
    bus.start            = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy",  bus.busy, 1'b0);
    check_eq("abort_done",  bus.done, 1'b0);
    check_eq("abort_label", bus.label_out, 0);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check_eq("abort_no_done", dones, 0);
    vote_case("after_rst", pack10(4, 6, 6, 4, 0, 0, 0, 0, 0, 0), 4, 4, 2, 5);

    // Back-to-back: start presented in the done cycle itself.
    run_vote(t1, 10, lat);
    check_eq("b2b_first", bus.label_out, 3);
    bus.neighbour_labels = pack10(6, 4, 4, 6, 0, 0, 0, 0, 0, 0);
    bus.n_valid          = CW'(4);
    bus.start            = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check_eq("b2b_lat", lat, 5);
    check_eq("b2b_label", bus.label_out, 6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
